// File: rtl/spi_flash_master_if.sv
// ---------------------------------------------------------------------------
// spi_flash_master_if
// IO-bus side of the SPI flash master: decoded strobes and write data from the
// CPU bus, and the received byte plus status returned for the io_din OR-mux.
//   wr_data  : one-cycle strobe, start a transfer of din
//   wr_ctrl  : one-cycle strobe, din[0] = cs_n level, din[1] = clear overrun
//   rd_data  : one-cycle strobe, CPU consumed rx_data (clears rx_valid)
//   din      : write data
//   rx_data  : last received byte
//   status   : {overrun, rx_valid, busy}
// Modports: master = bus/CPU side, slave = the SPI flash master block.
// ---------------------------------------------------------------------------
interface spi_flash_master_if;
    logic       wr_data;
    logic       wr_ctrl;
    logic       rd_data;
    logic [7:0] din;
    logic [7:0] rx_data;
    logic [2:0] status;

    modport master (
        output wr_data,
        output wr_ctrl,
        output rd_data,
        output din,
        input  rx_data,
        input  status
    );

    modport slave (
        input  wr_data,
        input  wr_ctrl,
        input  rd_data,
        input  din,
        output rx_data,
        output status
    );
endinterface

// File: rtl/spi_flash_master.sv
// ---------------------------------------------------------------------------
// spi_flash_master
// Byte-wide SPI mode-0 master for the configuration flash. One byte in
// flight, MSB first, SCK idles low. Chip select is purely software driven.
// Ports:
//   i_clk, i_reset : system clock, synchronous active-high reset
//   bus            : IO-bus strobes / data / status (slave modport)
//   o_sck          : SPI clock
//   o_mosi         : SPI data out
//   i_miso         : SPI data in (already registered by the pad flop)
//   o_cs_n         : flash chip select
// Parameter DIV is the SCK half-period in clk cycles (1..255).
// ---------------------------------------------------------------------------
module spi_flash_master #(
    parameter int unsigned DIV = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    spi_flash_master_if.slave bus,
    output logic              o_sck,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic              o_cs_n
);
    localparam int unsigned    HcW    = $clog2(DIV + 1);
    localparam logic [HcW-1:0] HcLast = HcW'(DIV - 1);

    typedef enum logic {StIdle, StXfer} state_t;

    state_t         r_state;
    logic [HcW-1:0] r_hc;
    logic [3:0]     r_ec;
    logic [7:0]     r_sr;
    logic [7:0]     r_rx_data;
    logic           r_sck;
    logic           r_mosi;
    logic           r_cs_n;
    logic           r_busy;
    logic           r_rx_valid;
    logic           r_overrun;

    logic w_tick;
    logic w_done;
    logic w_ovr_set;
    logic w_ovr_clr;

    // w_tick: SCK toggles this edge; w_done: the 16th toggle ends the byte
    assign w_tick    = r_busy && (r_hc == HcLast);
    assign w_done    = w_tick && (r_ec == 4'd15);
    // Any write while busy (including the completion edge) is an overrun
    assign w_ovr_set = r_busy && (bus.wr_data || bus.wr_ctrl);
    assign w_ovr_clr = bus.wr_ctrl && bus.din[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_hc       <= '0;
            r_ec       <= 4'd0;
            r_sr       <= 8'h00;
            r_rx_data  <= 8'h00;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // Set beats clear on the same edge
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_overrun <= 1'b0;
            end

            // Chip select is frozen for the whole byte
            if (bus.wr_ctrl && !r_busy) begin
                r_cs_n <= bus.din[0];
            end

            if (w_done) begin
                r_rx_valid <= 1'b1;
            end else if (bus.rd_data) begin
                r_rx_valid <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (bus.wr_data) begin
                        r_state <= StXfer;
                        r_busy  <= 1'b1;
                        r_sr    <= bus.din;
                        r_mosi  <= bus.din[7];
                        r_hc    <= '0;
                        r_ec    <= 4'd0;
                    end
                end
                StXfer: begin
                    if (w_tick) begin
                        r_hc  <= '0;
                        r_sck <= ~r_sck;
                        r_ec  <= r_ec + 4'd1;
                        if (!r_ec[0]) begin
                            // Rising SCK: sample miso on the same clk edge
                            r_sr <= {r_sr[6:0], i_miso};
                        end else if (w_done) begin
                            r_state   <= StIdle;
                            r_busy    <= 1'b0;
                            r_rx_data <= r_sr;
                        end else begin
                            // Falling SCK: present next bit, already shifted to sr[7]
                            r_mosi <= r_sr[7];
                        end
                    end else begin
                        r_hc <= r_hc + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.rx_data = r_rx_data;
    assign bus.status  = {r_overrun, r_rx_valid, r_busy};
    assign o_sck       = r_sck;
    assign o_mosi      = r_mosi;
    assign o_cs_n      = r_cs_n;

endmodule

// File: tb/tb_spi_flash_master.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_master
// Two instances: dut0 (DIV=2) with miso looped back to mosi, dut1 (DIV=1)
// driven by a mode-0 slave model returning 8'h3C. Expected transfer results
// are queued when a byte is started; per-DUT monitors pop and compare when
// busy falls. Static conditions are checked directly at the falling clk edge.
// ---------------------------------------------------------------------------
module tb_spi_flash_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic sck0, mosi0, cs0, miso0;
    logic sck1, mosi1, cs1, miso1;

    spi_flash_master_if bus0 ();
    spi_flash_master_if bus1 ();

    assign miso0 = mosi0;

    spi_flash_master #(.DIV(2)) u_dut0 (
        .i_clk   (clk),
        .i_reset (rst0),
        .bus     (bus0),
        .o_sck   (sck0),
        .o_mosi  (mosi0),
        .i_miso  (miso0),
        .o_cs_n  (cs0)
    );

    spi_flash_master #(.DIV(1)) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst1),
        .bus     (bus1),
        .o_sck   (sck1),
        .o_mosi  (mosi1),
        .i_miso  (miso1),
        .o_cs_n  (cs1)
    );

    // Slave model for dut1: bit index advances after each rising SCK
    logic [7:0] slv_byte = 8'h3C;
    logic [3:0] nrise1   = 4'd0;
    logic       sck1_q   = 1'b0;
    always @(posedge clk) begin
        sck1_q <= sck1;
        if (!bus1.status[0]) nrise1 <= 4'd0;
        else if (sck1 && !sck1_q) nrise1 <= nrise1 + 4'd1;
    end
    assign miso1 = nrise1[3] ? 1'b0 : slv_byte[~nrise1[2:0]];

    typedef struct {
        logic [7:0] rx;
        logic [2:0] st;
        int         cycles;
        logic [7:0] bits;
        int         rises;
        int         flips;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic check_xfer(input string tag, input exp_t e, input logic [7:0] rx,
                              input logic [2:0] st, input int cyc, input logic [7:0] bits,
                              input int rises, input int flips, input int sp_min,
                              input int sp_max, input int sp_exp);
        chk({tag, "_rx_data"}, 32'(rx), 32'(e.rx));
        chk({tag, "_status"}, 32'(st), 32'(e.st));
        chk({tag, "_busy_cycles"}, cyc, e.cycles);
        chk({tag, "_mosi_bits"}, 32'(bits), 32'(e.bits));
        chk({tag, "_sck_rises"}, rises, e.rises);
        chk({tag, "_mosi_flips"}, flips, e.flips);
        chk({tag, "_sck_spacing_min"}, sp_min, sp_exp);
        chk({tag, "_sck_spacing_max"}, sp_max, sp_exp);
    endtask

    // Monitors: collect per-transfer statistics, compare on busy falling
    logic rst0_q = 1'b1;
    logic rst1_q = 1'b1;
    always @(posedge clk) begin
        rst0_q <= rst0;
        rst1_q <= rst1;
    end

    always @(negedge clk) begin : mon0
        logic       b, b_p, s_p, m_p;
        int         cyc, rises, flips, last, sp_min, sp_max;
        logic [7:0] cap;
        exp_t       e;
        b = bus0.status[0];
        if (b && !b_p) begin
            cyc = 0; rises = 0; flips = 0; last = 0; cap = 8'h00;
            sp_min = 1000; sp_max = 0;
        end
        if (b) begin
            cyc++;
            if (b_p && (mosi0 !== m_p)) flips++;
        end
        if (sck0 && !s_p) begin
            cap = {cap[6:0], mosi0};
            if (rises > 0) begin
                if (cyc - last < sp_min) sp_min = cyc - last;
                if (cyc - last > sp_max) sp_max = cyc - last;
            end
            last = cyc;
            rises++;
        end
        if (!b && b_p === 1'b1 && rst0_q === 1'b0) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL dut0_unexpected_done: got completion, expected none");
            end else begin
                e = q0.pop_front();
                check_xfer("dut0", e, bus0.rx_data, bus0.status, cyc, cap, rises, flips,
                           sp_min, sp_max, 4);
            end
        end
        b_p = b; s_p = sck0; m_p = mosi0;
    end

    always @(negedge clk) begin : mon1
        logic       b, b_p, s_p, m_p;
        int         cyc, rises, flips, last, sp_min, sp_max;
        logic [7:0] cap;
        exp_t       e;
        b = bus1.status[0];
        if (b && !b_p) begin
            cyc = 0; rises = 0; flips = 0; last = 0; cap = 8'h00;
            sp_min = 1000; sp_max = 0;
        end
        if (b) begin
            cyc++;
            if (b_p && (mosi1 !== m_p)) flips++;
        end
        if (sck1 && !s_p) begin
            cap = {cap[6:0], mosi1};
            if (rises > 0) begin
                if (cyc - last < sp_min) sp_min = cyc - last;
                if (cyc - last > sp_max) sp_max = cyc - last;
            end
            last = cyc;
            rises++;
        end
        if (!b && b_p === 1'b1 && rst1_q === 1'b0) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL dut1_unexpected_done: got completion, expected none");
            end else begin
                e = q1.pop_front();
                check_xfer("dut1", e, bus1.rx_data, bus1.status, cyc, cap, rises, flips,
                           sp_min, sp_max, 2);
            end
        end
        b_p = b; s_p = sck1; m_p = mosi1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = wr_data, 1 = wr_ctrl, 2 = rd_data
    task automatic strobe0(input int kind, input logic [7:0] d);
        bus0.din     = d;
        bus0.wr_data = (kind == 0);
        bus0.wr_ctrl = (kind == 1);
        bus0.rd_data = (kind == 2);
        tick();
        bus0.wr_data = 1'b0;
        bus0.wr_ctrl = 1'b0;
        bus0.rd_data = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        while (((sel ? q1.size() : q0.size()) != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if ((sel ? q1.size() : q0.size()) != 0) begin
            n_total++;
            $display("FAIL dut%0d_timeout: got no completion, expected one within 200 cycles",
                     sel);
            if (sel) q1.delete();
            else q0.delete();
        end
    endtask

    initial begin
        bus0.wr_data = 1'b0; bus0.wr_ctrl = 1'b0; bus0.rd_data = 1'b0; bus0.din = 8'h00;
        bus1.wr_data = 1'b0; bus1.wr_ctrl = 1'b0; bus1.rd_data = 1'b0; bus1.din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_sck", 32'(sck0), 32'd0);
        chk("reset_mosi", 32'(mosi0), 32'd0);
        chk("reset_cs_n", 32'(cs0), 32'd1);
        chk("reset_status", 32'(bus0.status), 32'd0);
        chk("reset_rx_data", 32'(bus0.rx_data), 32'd0);
        chk("reset_dut1_status", 32'(bus1.status), 32'd0);
        tick();

        // Loopback, DIV=2
        strobe0(1, 8'h00);
        @(negedge clk);
        chk("ctrl_cs_n_low", 32'(cs0), 32'd0);
        tick();
        q0.push_back('{rx: 8'hA5, st: 3'b010, cycles: 32, bits: 8'hA5, rises: 8, flips: 6});
        strobe0(0, 8'hA5);
        wait_done(1'b0);

        // DIV=1 against slave model, cs_n left high
        q1.push_back('{rx: 8'h3C, st: 3'b010, cycles: 16, bits: 8'hFF, rises: 8, flips: 0});
        bus1.din     = 8'hFF;
        bus1.wr_data = 1'b1;
        tick();
        bus1.wr_data = 1'b0;
        wait_done(1'b1);

        // Overrun: second wr_data at T+5 is dropped
        q0.push_back('{rx: 8'h12, st: 3'b110, cycles: 32, bits: 8'h12, rises: 8, flips: 4});
        strobe0(0, 8'h12);
        repeat (4) tick();
        bus0.din     = 8'h34;
        bus0.wr_data = 1'b1;
        tick();
        bus0.wr_data = 1'b0;
        tick();
        @(negedge clk);
        chk("overrun_set_status", 32'(bus0.status), 32'b111);
        wait_done(1'b0);
        strobe0(1, 8'h02);
        @(negedge clk);
        chk("overrun_clear_status", 32'(bus0.status), 32'b010);
        chk("overrun_clear_cs_n", 32'(cs0), 32'd0);
        tick();

        // Coincident edges: wr_ctrl mid-transfer, rd_data on completion edge
        q0.push_back('{rx: 8'h5A, st: 3'b110, cycles: 32, bits: 8'h5A, rises: 8, flips: 6});
        strobe0(0, 8'h5A);
        repeat (9) tick();
        bus0.din     = 8'h01;
        bus0.wr_ctrl = 1'b1;
        tick();
        bus0.wr_ctrl = 1'b0;
        @(negedge clk);
        chk("midxfer_cs_n_held", 32'(cs0), 32'd0);
        chk("midxfer_status", 32'(bus0.status), 32'b111);
        repeat (21) tick();
        bus0.rd_data = 1'b1;
        tick();
        bus0.rd_data = 1'b0;
        wait_done(1'b0);
        strobe0(2, 8'h00);
        @(negedge clk);
        chk("rd_clears_rx_valid", 32'(bus0.status), 32'b100);
        tick();
        strobe0(1, 8'h02);
        @(negedge clk);
        chk("ctrl_clear_status", 32'(bus0.status), 32'b000);
        tick();

        // Reset mid-transfer at T+9, then a normal byte
        strobe0(0, 8'hC3);
        repeat (8) tick();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        @(negedge clk);
        chk("midreset_sck", 32'(sck0), 32'd0);
        chk("midreset_mosi", 32'(mosi0), 32'd0);
        chk("midreset_cs_n", 32'(cs0), 32'd1);
        chk("midreset_status", 32'(bus0.status), 32'b000);
        chk("midreset_rx_data", 32'(bus0.rx_data), 32'd0);
        tick();
        q0.push_back('{rx: 8'h81, st: 3'b010, cycles: 32, bits: 8'h81, rises: 8, flips: 2});
        strobe0(0, 8'h81);
        wait_done(1'b0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
